// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory among N_CORES
// requesters; each grant runs a full issue / wait / acknowledge transaction.
module mem_rr_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1,
    localparam int CORE_W = $clog2(N_CORES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          req_i,
    input  logic [N_CORES-1:0]          we_i,
    input  logic [N_CORES*ADDR_W-1:0]   addr_i,
    input  logic [N_CORES*DATA_W-1:0]   wdata_i,
    output logic [N_CORES-1:0]          ack_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic [CORE_W-1:0]           owner_o,
    output logic                        busy_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    output logic                        mem_wren_o,
    input  logic [DATA_W-1:0]           mem_rdata_i
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [CORE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CORE_W-1:0]   owner_q, owner_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_wren_q, mem_wren_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                gnt_found;
    logic [CORE_W-1:0]   gnt_idx;
    int                  j;

    // Scan downward in distance from rr_ptr so the nearest requester is written last and wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            j = int'(rr_ptr_q) + k;
            if (j >= N_CORES) j = j - N_CORES;
            if (req_i[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = CORE_W'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wren_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = mem_wren_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                mem_wren_d = 1'b0;
                if (gnt_found) begin
                    owner_d     = gnt_idx;
                    mem_addr_d  = addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
                    mem_wren_d  = we_i[gnt_idx];
                    cnt_d       = CNT_W'(RD_LAT - 1);
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                mem_wren_d = 1'b0;
                state_d    = mem_wren_q ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rdata_d = mem_rdata_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q == CORE_W'(N_CORES - 1)) rr_ptr_d = '0;
                else                                 rr_ptr_d = owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_o = '0;
        if (state_q == RESP) ack_o[owner_q] = 1'b1;
        busy_o      = (state_q != IDLE);
        rdata_o     = rdata_q;
        owner_o     = owner_q;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;
        mem_wren_o  = mem_wren_q;
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: RD_LAT=1 instance (a) with scoreboarded transactions,
// RD_LAT=2 instance (b) for the longer read latency.
module tb_mem_rr_arbiter;

    localparam int RD_LAT_A = 1;
    localparam int RD_LAT_B = 2;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [3:0]  req_a, we_a, ack_a;
    logic [63:0] addr_a, wdata_a;
    logic [15:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic [1:0]  owner_a;
    logic        busy_a, mem_wren_a;

    logic [3:0]  req_b, we_b, ack_b;
    logic [63:0] addr_b, wdata_b;
    logic [15:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [1:0]  owner_b;
    logic        busy_b, mem_wren_b;

    mem_rr_arbiter #(.N_CORES(4), .ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT_A)) dut_a (
        .clk(clk), .reset(reset), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
        .wdata_i(wdata_a), .ack_o(ack_a), .rdata_o(rdata_a), .owner_o(owner_a),
        .busy_o(busy_a), .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a),
        .mem_wren_o(mem_wren_a), .mem_rdata_i(mem_rdata_a));

    mem_rr_arbiter #(.N_CORES(4), .ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT_B)) dut_b (
        .clk(clk), .reset(reset), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
        .wdata_i(wdata_b), .ack_o(ack_b), .rdata_o(rdata_b), .owner_o(owner_b),
        .busy_o(busy_b), .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
        .mem_wren_o(mem_wren_b), .mem_rdata_i(mem_rdata_b));

    // Memory models: address sampled on the edge, data RD_LAT edges later.
    logic [15:0] mem_a [256];
    logic [15:0] rp_a;
    always @(posedge clk) begin
        if (mem_wren_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
        rp_a <= mem_a[mem_addr_a[7:0]];
    end
    assign mem_rdata_a = rp_a;

    logic [15:0] mem_b [256];
    logic [15:0] rp_b0, rp_b1;
    always @(posedge clk) begin
        if (mem_wren_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
        rp_b0 <= mem_b[mem_addr_b[7:0]];
        rp_b1 <= rp_b0;
    end
    assign mem_rdata_b = rp_b1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          core;
        logic [15:0] rdata;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   ack_times[$];

    typedef struct {
        int          core;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard consumer: every ack on instance a must match the oldest expectation.
    always @(negedge clk) begin
        if (ack_a != 4'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(ack_a), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_onehot", 32'(ack_a), 32'(4'b0001 << mon_e.core));
                check("ack_owner", 32'(owner_a), 32'(mon_e.core));
                check("ack_rdata", 32'(rdata_a), 32'(mon_e.rdata));
            end
        end
    end

    task automatic chk_rst_a();
        check("rst_ack", 32'(ack_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_rdata", 32'(rdata_a), 32'h0);
        check("rst_owner", 32'(owner_a), 32'h0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata_a), 32'h0);
        check("rst_mem_wren", 32'(mem_wren_a), 32'h0);
    endtask

    task automatic do_txn(input int c, input logic w, input logic [15:0] ad,
                          input logic [15:0] wd, input logic [15:0] er);
        int   cyc = 0;
        logic got = 1'b0;
        exp_t e;
        e.core  = c;
        e.rdata = er;
        @(posedge clk); #1;
        addr_a[c*16 +: 16]  = ad;
        wdata_a[c*16 +: 16] = wd;
        we_a[c]             = w;
        sb.push_back(e);
        req_a[c] = 1'b1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            if (cyc == 0) check("wren_cyc0", 32'(mem_wren_a), 32'h0);
            if (cyc == 1) begin
                check("wren_cyc1", 32'(mem_wren_a), 32'(w));
                check("mem_addr_cyc1", 32'(mem_addr_a), 32'(ad));
                if (w) check("mem_wdata_cyc1", 32'(mem_wdata_a), 32'(wd));
                check("busy_cyc1", 32'(busy_a), 32'h1);
            end
            if (cyc == 2) check("wren_cyc2", 32'(mem_wren_a), 32'h0);
            if (ack_a[c]) got = 1'b1;
            else          cyc++;
        end
        check("ack_latency", 32'(cyc), w ? 32'd2 : 32'(RD_LAT_A + 2));
        @(posedge clk); #1;
        req_a[c] = 1'b0;
        @(negedge clk);
        check("busy_after_ack", 32'(busy_a), 32'h0);
    endtask

    // Drive a request set; cores not in keep drop req on their ack edge.
    task automatic run_seq(input logic [3:0] r, input logic [3:0] keep, input int n, input int budget);
        int         cyc = 0;
        int         got = 0;
        logic [3:0] a;
        ack_times.delete();
        @(posedge clk); #1;
        req_a = r;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            a = ack_a;
            if (a != 4'b0) begin
                ack_times.push_back(cyc);
                got++;
            end
            cyc++;
            @(posedge clk); #1;
            req_a = req_a & ~(a & ~keep);
        end
        check("seq_ack_count", 32'(got), 32'(n));
        req_a = 4'b0;
    endtask

    function automatic exp_t mk(input int c, input logic [15:0] d);
        exp_t e;
        e.core  = c;
        e.rdata = d;
        return e;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[1] = '{0, 1'b1, 16'h0005, 16'h1234, 16'h0000};
        vecs[2] = '{2, 1'b0, 16'h0005, 16'h0000, 16'h1234};
        vecs[3] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[4] = '{0, 1'b1, 16'h00FF, 16'hA5A5, 16'hBEEF};
        vecs[5] = '{2, 1'b0, 16'h00FF, 16'h0000, 16'hA5A5};
        vecs[6] = '{3, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[7] = '{3, 1'b1, 16'h0000, 16'h0001, 16'hBEEF};

        reset = 1'b1;
        req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_rst_a();
        check("rst_b_busy", 32'(busy_b), 32'h0);
        check("rst_b_ack", 32'(ack_b), 32'h0);
        reset = 1'b0;

        // Instance b: core 0 writes BEEF to 0x0010, then core 3 reads it back.
        @(posedge clk); #1;
        addr_b[15:0] = 16'h0010; wdata_b[15:0] = 16'hBEEF; we_b[0] = 1'b1; req_b[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack_b[0]) begin
                check("b_write_latency", 32'(k), 32'd2);
                check("b_write_rdata", 32'(rdata_b), 32'h0);
                break;
            end
            if (k == 9) check("b_write_timeout", 32'(ack_b), 32'h1);
        end
        @(posedge clk); #1;
        req_b[0] = 1'b0;
        @(posedge clk); #1;
        addr_b[63:48] = 16'h0010; we_b[3] = 1'b0; req_b[3] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) check("b_read_no_ack", 32'(ack_b), 32'h0);
            if (k == 2) check("b_read_busy", 32'(busy_b), 32'h1);
            if (k == 3) check("b_rdata_before", 32'(rdata_b), 32'h0);
            if (k == 4) begin
                check("b_read_ack", 32'(ack_b), 32'h8);
                check("b_read_rdata", 32'(rdata_b), 32'hBEEF);
                @(posedge clk); #1;
                req_b[3] = 1'b0;
            end
            if (k == 5) check("b_busy_low", 32'(busy_b), 32'h0);
        end

        // Table of single transactions on instance a.
        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].core, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // All four cores read at once and keep requesting: order 0..3 twice, 4 cycles apart.
        we_a = 4'b0;
        addr_a = {16'h00FF, 16'h0010, 16'h0005, 16'h0000};
        for (int r = 0; r < 2; r++) begin
            sb.push_back(mk(0, 16'h0001));
            sb.push_back(mk(1, 16'h1234));
            sb.push_back(mk(2, 16'hBEEF));
            sb.push_back(mk(3, 16'hA5A5));
        end
        run_seq(4'hF, 4'hF, 8, 100);
        if (ack_times.size() > 0) check("all_first_ack", 32'(ack_times[0]), 32'd3);
        for (int i = 1; i < ack_times.size(); i++)
            check("all_ack_spacing", 32'(ack_times[i] - ack_times[i-1]), 32'd4);

        // Fairness: core 0 writes continuously, core 2 reads once and must come second.
        we_a[0] = 1'b1; addr_a[15:0] = 16'h0040; wdata_a[15:0] = 16'h7777;
        we_a[2] = 1'b0; addr_a[47:32] = 16'h0005;
        sb.push_back(mk(0, 16'hA5A5));
        sb.push_back(mk(2, 16'h1234));
        sb.push_back(mk(0, 16'h1234));
        sb.push_back(mk(0, 16'h1234));
        run_seq(4'b0101, 4'b0001, 4, 100);
        if (ack_times.size() > 1) check("fair_core2_ack", 32'(ack_times[1]), 32'd6);

        // Reset during WAIT of a core 1 read: no ack may follow.
        we_a = 4'b0;
        addr_a[31:16] = 16'h0005;
        @(posedge clk); #1;
        req_a[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("wait_busy", 32'(busy_a), 32'h1);
        check("wait_owner", 32'(owner_a), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk_rst_a();
        req_a = 4'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold_ack", 32'(ack_a), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // After release rr_ptr must be 0: cores 0 and 1 together are served 0 then 1.
        addr_a[15:0] = 16'h0005; addr_a[31:16] = 16'h0010;
        sb.push_back(mk(0, 16'h1234));
        sb.push_back(mk(1, 16'hBEEF));
        run_seq(4'b0011, 4'b0000, 2, 50);
        if (ack_times.size() > 0) check("post_rst_first_ack", 32'(ack_times[0]), 32'd3);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
